// File: rtl/ifq_pkg.sv
// ifq_pkg: shared sizing and types for the instruction fetch align queue.
package ifq_pkg;
    localparam int LINE_BYTES = 16;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int LEN_W      = OFF_W + 1;
    localparam int AVL_W      = OFF_W + 2;
    typedef logic [LINE_BYTES*8-1:0] line_t;
endpackage

// File: rtl/ifetch_align_queue_if.sv
// ifetch_align_queue_if: fetch-side line handshake plus decode-side window and consume signals.
interface ifetch_align_queue_if;
    import ifq_pkg::*;
    logic                    line_valid;
    line_t                   line_data;
    logic                    line_ready;
    logic                    flush;
    logic [OFF_W-1:0]        flush_off;
    logic                    consume_en;
    logic [LEN_W-1:0]        consume_len;
    logic [2*LINE_BYTES*8-1:0] win_data;
    logic [OFF_W:0]          win_amt;
    logic [AVL_W-1:0]        win_avail;
    logic                    err_ovr;
    modport master (
        output line_valid, line_data, flush, flush_off, consume_en, consume_len,
        input  line_ready, win_data, win_amt, win_avail, err_ovr
    );
    modport slave (
        input  line_valid, line_data, flush, flush_off, consume_en, consume_len,
        output line_ready, win_data, win_amt, win_avail, err_ovr
    );
endinterface

// File: rtl/ifq_line_reg.sv
// ifq_line_reg: one fetch line register with load enable.
module ifq_line_reg
    import ifq_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en_i,
    input  line_t d_i,
    output line_t q_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_o <= '0;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/ifetch_align_queue.sv
// ifetch_align_queue: two-line fetch queue presenting a {next, head} rotate window to decode.
// Define IFQ_OVR_CHECK_EN to enable the sticky over-consume flag err_ovr.
module ifetch_align_queue
    import ifq_pkg::*;
(
    input logic clk,
    input logic rst_n,
    ifetch_align_queue_if.slave bus
);
    logic [1:0]       count_q, count_d, count_pop;
    logic [OFF_W-1:0] off_q, off_d, off_c, pend_q, pend_d;
    logic [LEN_W-1:0] s;
    logic [AVL_W-1:0] avail;
    logic             err_q, err_d, bad, go, pop, wr, wr_head, head_en, next_en;
    line_t            head_q, next_q, head_src;

    assign avail = (count_q != 2'd0 ? AVL_W'(LINE_BYTES) - AVL_W'(off_q) : '0)
                 + (count_q == 2'd2 ? AVL_W'(LINE_BYTES) : '0);
    assign bad   = bus.consume_en & ((bus.consume_len > LEN_W'(LINE_BYTES)) |
                                     (AVL_W'(bus.consume_len) > avail));
    assign go    = bus.consume_en & ~bad & ~bus.flush;
    assign s     = LEN_W'(off_q) + bus.consume_len;
    // s never exceeds 2*LINE_BYTES-1, so its top bit alone marks a line crossing
    assign pop       = go & s[OFF_W];
    assign off_c     = go ? s[OFF_W-1:0] : off_q;
    assign count_pop = count_q - {1'b0, pop};
    assign wr        = bus.line_valid & bus.line_ready;
    assign wr_head   = wr & (count_pop == 2'd0);
    assign head_en   = wr_head | (pop & (count_q == 2'd2));
    assign next_en   = wr & ~wr_head;
    assign head_src  = wr_head ? bus.line_data : next_q;

    always_comb begin
        count_d = bus.flush ? 2'd0 : count_pop + {1'b0, wr};
        off_d   = bus.flush ? '0 : (wr_head & (count_q == 2'd0)) ? pend_q : off_c;
        pend_d  = bus.flush ? bus.flush_off : wr_head ? '0 :
                  (pop & (count_pop == 2'd0)) ? off_c : pend_q;
    end

`ifdef IFQ_OVR_CHECK_EN
    assign err_d = err_q | (bad & ~bus.flush);
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            off_q   <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            off_q   <= off_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    ifq_line_reg u_head (.clk(clk), .rst_n(rst_n), .en_i(head_en), .d_i(head_src),      .q_o(head_q));
    ifq_line_reg u_next (.clk(clk), .rst_n(rst_n), .en_i(next_en), .d_i(bus.line_data), .q_o(next_q));

    assign bus.line_ready = ~count_q[1] & ~bus.flush;
    assign bus.win_data   = {next_q, head_q};
    assign bus.win_amt    = {1'b0, off_q};
    assign bus.win_avail  = avail;
    assign bus.err_ovr    = err_q;
endmodule

// File: tb/tb_ifetch_align_queue.sv
// tb_ifetch_align_queue: directed vector table, reset corner case and randomized run
// against a line-queue reference model.
module tb_ifetch_align_queue;
    import ifq_pkg::*;

    typedef struct {
        logic       lv;
        int         li;
        logic       fl;
        logic [3:0] fo;
        logic       ce;
        logic [4:0] cl;
        int         avail;
        int         amt;
        logic       rdy;
    } vec_t;

    logic clk = 0;
    logic rst_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    line_t mq[$];
    int    moff = 0;
    int    mpend = 0;
    logic  merr = 0;
    line_t lines[4];
    vec_t  tbl[17];

    ifetch_align_queue_if bus();
    ifetch_align_queue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int mavail();
        return mq.size() == 0 ? 0 : mq.size() * LINE_BYTES - moff;
    endfunction

    task automatic model_reset();
        mq.delete();
        moff = 0;
        mpend = 0;
        merr = 0;
    endtask

    task automatic model_step(logic lv, line_t ld, logic fl, logic [3:0] fo, logic ce, int cl);
        int av;
        bit wr;
        bit popped;
        popped = 0;
        if (fl) begin
            mq.delete();
            moff = 0;
            mpend = fo;
            return;
        end
        av = mavail();
        wr = lv && mq.size() < 2;
        if (ce && (cl > av || cl > LINE_BYTES)) begin
`ifdef IFQ_OVR_CHECK_EN
            merr = 1;
`endif
        end else if (ce) begin
            moff += cl;
            if (moff >= LINE_BYTES) begin
                void'(mq.pop_front());
                moff -= LINE_BYTES;
                popped = 1;
                if (mq.size() == 0 && !wr) mpend = moff;
            end
        end
        if (wr) begin
            if (mq.size() == 0) begin
                if (!popped) moff = mpend;
                mpend = 0;
            end
            mq.push_back(ld);
        end
    endtask

    task automatic check_model();
        chk("avail", bus.win_avail, mavail());
        chk("amt", bus.win_amt, moff);
        chk("ready", bus.line_ready, mq.size() < 2);
        chk("err", bus.err_ovr, merr);
        if (mq.size() >= 1) chk("head", bus.win_data[LINE_BYTES*8-1:0], mq[0]);
        if (mq.size() == 2) chk("next", bus.win_data[2*LINE_BYTES*8-1:LINE_BYTES*8], mq[1]);
    endtask

    task automatic idle();
        bus.line_valid = 0;
        bus.flush = 0;
        bus.consume_en = 0;
    endtask

    task automatic tick(logic lv, line_t ld, logic fl, logic [3:0] fo, logic ce, logic [4:0] cl);
        bus.line_valid = lv;
        bus.line_data = ld;
        bus.flush = fl;
        bus.flush_off = fo;
        bus.consume_en = ce;
        bus.consume_len = cl;
        #1;
        chk("ready_comb", bus.line_ready, (mq.size() < 2) && !fl);
        model_step(lv, ld, fl, fo, ce, int'(cl));
        @(posedge clk);
        #1;
        idle();
        #1;
        check_model();
    endtask

    initial begin
        int cl;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < LINE_BYTES; b++)
                lines[i][b*8 +: 8] = 8'(i * 16 + b + 1);
        //          lv li fl fo ce cl  avail amt rdy
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  16, 0,  1};
        tbl[1]  = '{1, 1, 0, 0, 0, 0,  32, 0,  0};
        tbl[2]  = '{0, 0, 0, 0, 1, 5,  27, 5,  0};
        tbl[3]  = '{0, 0, 0, 0, 1, 13, 14, 2,  1};
        tbl[4]  = '{0, 0, 0, 0, 1, 10, 4,  12, 1};
        tbl[5]  = '{1, 2, 0, 0, 1, 4,  16, 0,  1};
        tbl[6]  = '{1, 3, 1, 9, 0, 0,  0,  0,  1};
        tbl[7]  = '{1, 3, 0, 0, 0, 0,  7,  9,  1};
        tbl[8]  = '{0, 0, 0, 0, 1, 4,  3,  13, 1};
        tbl[9]  = '{0, 0, 0, 0, 1, 6,  3,  13, 1};
        tbl[10] = '{0, 0, 0, 0, 1, 0,  3,  13, 1};
        tbl[11] = '{0, 0, 0, 0, 1, 3,  0,  0,  1};
        tbl[12] = '{1, 0, 0, 0, 0, 0,  16, 0,  1};
        tbl[13] = '{1, 1, 0, 0, 0, 0,  32, 0,  0};
        tbl[14] = '{0, 0, 0, 0, 1, 16, 16, 0,  1};
        tbl[15] = '{0, 0, 0, 0, 1, 17, 16, 0,  1};
        tbl[16] = '{1, 2, 0, 0, 1, 16, 16, 0,  1};

        idle();
        bus.line_data = '0;
        bus.flush_off = '0;
        bus.consume_len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_avail", bus.win_avail, 0);
        chk("rst_amt", bus.win_amt, 0);
        chk("rst_ready", bus.line_ready, 1);
        chk("rst_data", bus.win_data, 0);
        chk("rst_err", bus.err_ovr, 0);
        rst_n = 1;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].lv, lines[tbl[i].li], tbl[i].fl, tbl[i].fo, tbl[i].ce, tbl[i].cl);
            chk($sformatf("vec%0d_avail", i), bus.win_avail, tbl[i].avail);
            chk($sformatf("vec%0d_amt", i), bus.win_amt, tbl[i].amt);
            chk($sformatf("vec%0d_ready", i), bus.line_ready, tbl[i].rdy);
        end
`ifdef IFQ_OVR_CHECK_EN
        chk("ovr_sticky", bus.err_ovr, 1);
`else
        chk("ovr_tied", bus.err_ovr, 0);
`endif

        // mid-stream asynchronous reset with two lines held and offset 7
        tick(1, '0, 1, 0, 0, 0);
        tick(1, lines[0], 0, 0, 0, 0);
        tick(1, lines[1], 0, 0, 0, 0);
        tick(0, '0, 0, 0, 1, 7);
        chk("pre_rst_amt", bus.win_amt, 7);
        chk("pre_rst_avail", bus.win_avail, 25);
        rst_n = 0;
        #1;
        chk("arst_avail", bus.win_avail, 0);
        chk("arst_amt", bus.win_amt, 0);
        chk("arst_ready", bus.line_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_data", bus.win_data, 0);
        check_model();
        rst_n = 1;
        #1;

        for (int n = 0; n < 3000; n++) begin
            line_t ld;
            logic  ce;
            ld = {$urandom, $urandom, $urandom, $urandom};
            ce = $urandom_range(0, 9) < 6;
            if ($urandom_range(0, 9) == 0) cl = $urandom_range(17, 31);
            else if ($urandom_range(0, 1) == 0) cl = $urandom_range(0, mavail() > 16 ? 16 : mavail());
            else cl = $urandom_range(0, 16);
            tick($urandom_range(0, 9) < 6, ld, $urandom_range(0, 19) == 0,
                 4'($urandom), ce, 5'(cl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
